// File: rtl/rpn_wan_rx_multi.sv
// rpn_wan_rx_multi
//   Multi-sender RPN WAN receive path. Accepts single-beat packets from the
//   Network Bridge, keeps a last-accepted sequence number per remote cluster
//   in an internal table, forwards in-order PUB payloads to Control, drops
//   duplicates and gapped packets, and answers SEQ_NUM_CHECK requests (and
//   optionally gaps) with a SEQ_NUM_REPLY on the KnownIP stream.
//
// Ports
//   i_clk, i_ap_rst          clock, synchronous active-high reset
//   i_cluster_id             local cluster ID placed in replies
//   i_gateway_ip_address     reserved, not used by the datapath
//   i_KIP_port_number        destination port for KIP replies
//   from_nb_*                RX stream, tuser = source IP
//   to_ctrl_*                PUB payload stream to Control
//   to_nb_KIP_*              reply stream, tuser = {port, source IP}
//   o_*_drop_count           saturating drop counters
//
// state  | meaning
// IDLE   | ready for one RX beat
// LOOKUP | CTID compare against table, register hit / free index
// DECIDE | sequence check, table update, counters
// FWD    | present payload to Control until accepted
// REPLY  | present SEQ_NUM_REPLY on KIP until accepted
module rpn_wan_rx_multi #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int IP_ADDRESS_WIDTH = 32,
    parameter int IP_PORT_WIDTH    = 16,
    parameter int CTID_WIDTH       = 32,
    parameter int SEQ_WIDTH        = 32,
    parameter int NUM_SENDERS      = 8,
    parameter int PAYLOAD_OFFSET   = 80,
    parameter bit NACK_ON_GAP      = 1'b1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                    i_clk,
    input  logic                                    i_ap_rst,
    input  logic [CTID_WIDTH-1:0]                   i_cluster_id,
    input  logic [IP_ADDRESS_WIDTH-1:0]             i_gateway_ip_address,
    input  logic [IP_PORT_WIDTH-1:0]                i_KIP_port_number,
    input  logic                                    from_nb_tvalid,
    output logic                                    from_nb_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]              from_nb_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]            from_nb_tkeep,
    input  logic [IP_PORT_WIDTH-1:0]                from_nb_tid,
    input  logic [IP_PORT_WIDTH-1:0]                from_nb_tdest,
    input  logic [IP_ADDRESS_WIDTH-1:0]             from_nb_tuser,
    input  logic                                    from_nb_tlast,
    output logic                                    to_ctrl_tvalid,
    input  logic                                    to_ctrl_tready,
    output logic [AXIS_DATA_WIDTH-1:0]              to_ctrl_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]            to_ctrl_tkeep,
    output logic [IP_PORT_WIDTH-1:0]                to_ctrl_tid,
    output logic [IP_PORT_WIDTH-1:0]                to_ctrl_tdest,
    output logic [IP_ADDRESS_WIDTH-1:0]             to_ctrl_tuser,
    output logic                                    to_ctrl_tlast,
    output logic                                    to_nb_KIP_tvalid,
    input  logic                                    to_nb_KIP_tready,
    output logic [AXIS_DATA_WIDTH-1:0]              to_nb_KIP_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]            to_nb_KIP_tkeep,
    output logic [IP_ADDRESS_WIDTH+IP_PORT_WIDTH-1:0] to_nb_KIP_tuser,
    output logic                                    to_nb_KIP_tlast,
    output logic [CNT_WIDTH-1:0]                    o_dup_drop_count,
    output logic [CNT_WIDTH-1:0]                    o_gap_drop_count,
    output logic [CNT_WIDTH-1:0]                    o_full_drop_count
);
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SENDERS > 1) ? $clog2(NUM_SENDERS) : 1;
    localparam logic [7:0] TYPE_PUB   = 8'd1;
    localparam logic [7:0] TYPE_CHECK = 8'd2;
    localparam logic [7:0] TYPE_REPLY = 8'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DECIDE, S_FWD, S_REPLY} state_t;
    state_t state_q, state_d;

    logic [AXIS_DATA_WIDTH-1:0]  rx_data_q;
    logic [IP_PORT_WIDTH-1:0]    rx_tid_q, rx_tdest_q;
    logic [IP_ADDRESS_WIDTH-1:0] rx_tuser_q;
    logic [NUM_SENDERS-1:0]      tbl_valid_q;
    logic [CTID_WIDTH-1:0]       tbl_ctid_q [NUM_SENDERS];
    logic [SEQ_WIDTH-1:0]        tbl_seq_q  [NUM_SENDERS];
    logic                        hit_q, free_q;
    logic [IDX_W-1:0]            hit_idx_q, free_idx_q;
    logic [SEQ_WIDTH-1:0]        reply_seq_q;
    logic [CNT_WIDTH-1:0]        dup_cnt_q, gap_cnt_q, full_cnt_q;

    logic [7:0]            rx_type;
    logic [CTID_WIDTH-1:0] rx_ctid;
    logic [SEQ_WIDTH-1:0]  rx_seq;
    logic                  in_accept;
    logic                  lk_hit, lk_free;
    logic [IDX_W-1:0]      lk_hit_idx, lk_free_idx, wr_idx;
    logic [SEQ_WIDTH-1:0]  last_seq, seq_diff;
    logic                  is_pub, pub_known, in_order, is_dup;
    logic                  unused_ok;

    assign rx_type = rx_data_q[7:0];
    assign rx_ctid = rx_data_q[8 +: CTID_WIDTH];
    assign rx_seq  = rx_data_q[8 + CTID_WIDTH +: SEQ_WIDTH];

    // Non-final beats and unknown types are taken off the bus and ignored.
    assign in_accept = from_nb_tvalid && from_nb_tready && from_nb_tlast &&
                       (from_nb_tdata[7:0] == TYPE_PUB || from_nb_tdata[7:0] == TYPE_CHECK);

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        lk_hit      = 1'b0;
        lk_hit_idx  = '0;
        lk_free     = 1'b0;
        lk_free_idx = '0;
        for (int i = NUM_SENDERS - 1; i >= 0; i--) begin
            if (tbl_valid_q[i] && tbl_ctid_q[i] == rx_ctid) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IDX_W'(i);
            end
            if (!tbl_valid_q[i]) begin
                lk_free     = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
        end
    end

    // A freshly allocated sender starts at all-ones so that seq 0 is in order.
    assign last_seq  = hit_q ? tbl_seq_q[hit_idx_q] : '1;
    assign seq_diff  = rx_seq - last_seq;
    assign is_pub    = (rx_type == TYPE_PUB);
    assign pub_known = is_pub && (hit_q || free_q);
    assign in_order  = (seq_diff == SEQ_WIDTH'(1));
    assign is_dup    = (seq_diff == '0) || seq_diff[SEQ_WIDTH-1];
    assign wr_idx    = hit_q ? hit_idx_q : free_idx_q;

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_DECIDE;
            S_DECIDE: begin
                if (!is_pub)            state_d = S_REPLY;
                else if (!pub_known)    state_d = S_IDLE;
                else if (in_order)      state_d = S_FWD;
                else if (is_dup)        state_d = S_IDLE;
                else if (NACK_ON_GAP)   state_d = S_REPLY;
                else                    state_d = S_IDLE;
            end
            S_FWD:    if (to_ctrl_tready)   state_d = S_IDLE;
            S_REPLY:  if (to_nb_KIP_tready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            rx_data_q   <= '0;
            rx_tid_q    <= '0;
            rx_tdest_q  <= '0;
            rx_tuser_q  <= '0;
            tbl_valid_q <= '0;
            hit_q       <= 1'b0;
            free_q      <= 1'b0;
            hit_idx_q   <= '0;
            free_idx_q  <= '0;
            reply_seq_q <= '0;
            dup_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            full_cnt_q  <= '0;
            for (int i = 0; i < NUM_SENDERS; i++) begin
                tbl_ctid_q[i] <= '0;
                tbl_seq_q[i]  <= '0;
            end
        end else begin
            if (state_q == S_IDLE && in_accept) begin
                rx_data_q  <= from_nb_tdata;
                rx_tid_q   <= from_nb_tid;
                rx_tdest_q <= from_nb_tdest;
                rx_tuser_q <= from_nb_tuser;
            end
            if (state_q == S_LOOKUP) begin
                hit_q      <= lk_hit;
                hit_idx_q  <= lk_hit_idx;
                free_q     <= lk_free;
                free_idx_q <= lk_free_idx;
            end
            if (state_q == S_DECIDE) begin
                reply_seq_q <= last_seq;
                if (pub_known) begin
                    tbl_valid_q[wr_idx] <= 1'b1;
                    tbl_ctid_q[wr_idx]  <= rx_ctid;
                    if (in_order)    tbl_seq_q[wr_idx] <= rx_seq;
                    else if (!hit_q) tbl_seq_q[wr_idx] <= '1;
                    if (!in_order && is_dup && dup_cnt_q != '1)
                        dup_cnt_q <= dup_cnt_q + CNT_WIDTH'(1);
                    if (!in_order && !is_dup && gap_cnt_q != '1)
                        gap_cnt_q <= gap_cnt_q + CNT_WIDTH'(1);
                end
                if (is_pub && !pub_known && full_cnt_q != '1)
                    full_cnt_q <= full_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        from_nb_tready   = (state_q == S_IDLE) && !i_ap_rst;
        to_ctrl_tvalid   = (state_q == S_FWD);
        to_ctrl_tdata    = '0;
        to_ctrl_tkeep    = '0;
        to_ctrl_tid      = '0;
        to_ctrl_tdest    = '0;
        to_ctrl_tuser    = '0;
        to_ctrl_tlast    = 1'b0;
        to_nb_KIP_tvalid = (state_q == S_REPLY);
        to_nb_KIP_tdata  = '0;
        to_nb_KIP_tkeep  = '0;
        to_nb_KIP_tuser  = '0;
        to_nb_KIP_tlast  = 1'b0;
        if (state_q == S_FWD) begin
            to_ctrl_tdata = rx_data_q >> PAYLOAD_OFFSET;
            to_ctrl_tkeep = {KEEP_W{1'b1}};
            to_ctrl_tid   = rx_tid_q;
            to_ctrl_tdest = rx_tdest_q;
            to_ctrl_tuser = rx_tuser_q;
            to_ctrl_tlast = 1'b1;
        end
        if (state_q == S_REPLY) begin
            to_nb_KIP_tdata = AXIS_DATA_WIDTH'({reply_seq_q, i_cluster_id, TYPE_REPLY});
            to_nb_KIP_tkeep = {KEEP_W{1'b1}};
            to_nb_KIP_tuser = {i_KIP_port_number, rx_tuser_q};
            to_nb_KIP_tlast = 1'b1;
        end
    end

    assign o_dup_drop_count  = dup_cnt_q;
    assign o_gap_drop_count  = gap_cnt_q;
    assign o_full_drop_count = full_cnt_q;

    assign unused_ok = ^{i_gateway_ip_address, from_nb_tkeep};
endmodule

// File: tb/tb_rpn_wan_rx_multi.sv
module tb_rpn_wan_rx_multi;
    localparam int DW   = 512;
    localparam int KW   = DW / 8;
    localparam int IPW  = 32;
    localparam int PW   = 16;
    localparam int CW   = 32;
    localparam int SW   = 32;
    localparam int NS   = 8;
    localparam int POFF = 80;
    localparam int CNTW = 16;
    localparam logic [CW-1:0] LOCAL_CID = 32'h1122_3344;
    localparam logic [PW-1:0] KIP_PORT  = 16'h00FB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            from_nb_tvalid = 1'b0, from_nb_tready;
    logic [DW-1:0]   from_nb_tdata = '0;
    logic [KW-1:0]   from_nb_tkeep = '1;
    logic [PW-1:0]   from_nb_tid = '0, from_nb_tdest = '0;
    logic [IPW-1:0]  from_nb_tuser = '0;
    logic            from_nb_tlast = 1'b0;
    logic            to_ctrl_tvalid, to_ctrl_tready = 1'b0;
    logic [DW-1:0]   to_ctrl_tdata;
    logic [KW-1:0]   to_ctrl_tkeep;
    logic [PW-1:0]   to_ctrl_tid, to_ctrl_tdest;
    logic [IPW-1:0]  to_ctrl_tuser;
    logic            to_ctrl_tlast;
    logic            kip_tvalid, kip_tready = 1'b0;
    logic [DW-1:0]   kip_tdata;
    logic [KW-1:0]   kip_tkeep;
    logic [IPW+PW-1:0] kip_tuser;
    logic            kip_tlast;
    logic [CNTW-1:0] dup_cnt, gap_cnt, full_cnt;

    rpn_wan_rx_multi dut (
        .i_clk(clk), .i_ap_rst(rst), .i_cluster_id(LOCAL_CID),
        .i_gateway_ip_address(32'hC0A8_0001), .i_KIP_port_number(KIP_PORT),
        .from_nb_tvalid(from_nb_tvalid), .from_nb_tready(from_nb_tready),
        .from_nb_tdata(from_nb_tdata), .from_nb_tkeep(from_nb_tkeep),
        .from_nb_tid(from_nb_tid), .from_nb_tdest(from_nb_tdest),
        .from_nb_tuser(from_nb_tuser), .from_nb_tlast(from_nb_tlast),
        .to_ctrl_tvalid(to_ctrl_tvalid), .to_ctrl_tready(to_ctrl_tready),
        .to_ctrl_tdata(to_ctrl_tdata), .to_ctrl_tkeep(to_ctrl_tkeep),
        .to_ctrl_tid(to_ctrl_tid), .to_ctrl_tdest(to_ctrl_tdest),
        .to_ctrl_tuser(to_ctrl_tuser), .to_ctrl_tlast(to_ctrl_tlast),
        .to_nb_KIP_tvalid(kip_tvalid), .to_nb_KIP_tready(kip_tready),
        .to_nb_KIP_tdata(kip_tdata), .to_nb_KIP_tkeep(kip_tkeep),
        .to_nb_KIP_tuser(kip_tuser), .to_nb_KIP_tlast(kip_tlast),
        .o_dup_drop_count(dup_cnt), .o_gap_drop_count(gap_cnt),
        .o_full_drop_count(full_cnt)
    );

    typedef struct { logic [DW-1:0] data; logic [PW-1:0] tid; logic [PW-1:0] tdest; logic [IPW-1:0] user; } ctrl_t;
    typedef struct { logic [DW-1:0] data; logic [IPW+PW-1:0] user; } kip_t;
    ctrl_t ctrl_q[$];
    kip_t  kip_q[$];
    logic [SW-1:0] model_last [logic [CW-1:0]];
    int unsigned m_dup = 0, m_gap = 0, m_full = 0;
    int checks = 0, errors = 0;
    int ctrl_mode = 1, kip_mode = 1;   // 0 random, 1 always ready, 2 stalled

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        to_ctrl_tready = (ctrl_mode == 0) ? ($urandom_range(0, 3) != 0) : (ctrl_mode == 1);
        kip_tready     = (kip_mode == 0)  ? ($urandom_range(0, 2) != 0) : (kip_mode == 1);
    end

    // Scoreboard monitor: compare every output handshake with the queue head.
    always @(negedge clk) begin
        ctrl_t ce;
        kip_t  ke;
        if (!rst) begin
            if (to_ctrl_tvalid && to_ctrl_tready) begin
                if (ctrl_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ctrl_unexpected actual=%0h required=none", to_ctrl_tdata);
                end else begin
                    ce = ctrl_q.pop_front();
                    chk("ctrl_tdata", to_ctrl_tdata, ce.data);
                    chk("ctrl_tid", DW'(to_ctrl_tid), DW'(ce.tid));
                    chk("ctrl_tdest", DW'(to_ctrl_tdest), DW'(ce.tdest));
                    chk("ctrl_tuser", DW'(to_ctrl_tuser), DW'(ce.user));
                    chk("ctrl_tkeep", DW'(to_ctrl_tkeep), DW'({KW{1'b1}}));
                    chk("ctrl_tlast", DW'(to_ctrl_tlast), DW'(1));
                end
            end
            if (kip_tvalid && kip_tready) begin
                if (kip_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL kip_unexpected actual=%0h required=none", kip_tdata);
                end else begin
                    ke = kip_q.pop_front();
                    chk("kip_tdata", kip_tdata, ke.data);
                    chk("kip_tuser", DW'(kip_tuser), DW'(ke.user));
                    chk("kip_tkeep", DW'(kip_tkeep), DW'({KW{1'b1}}));
                    chk("kip_tlast", DW'(kip_tlast), DW'(1));
                end
            end
        end
    end

    // Reference model: sequence rules applied to a CTID-indexed map.
    function automatic void model(input logic [7:0] typ, input logic [CW-1:0] ctid, input logic [SW-1:0] seq,
                                  input logic tl, input logic [DW-1:0] d, input logic [PW-1:0] tid,
                                  input logic [PW-1:0] tdest, input logic [IPW-1:0] ip);
        logic [SW-1:0] last, diff;
        ctrl_t c;
        kip_t k;
        if (!tl || !(typ == 8'd1 || typ == 8'd2)) return;
        if (typ == 8'd2) begin
            last = model_last.exists(ctid) ? model_last[ctid] : {SW{1'b1}};
            k.data = DW'({last, LOCAL_CID, 8'd3});
            k.user = {KIP_PORT, ip};
            kip_q.push_back(k);
            return;
        end
        if (!model_last.exists(ctid)) begin
            if (model_last.num() >= NS) begin
                m_full++;
                return;
            end
            model_last[ctid] = {SW{1'b1}};
        end
        last = model_last[ctid];
        diff = seq - last;
        if (diff == 1) begin
            model_last[ctid] = seq;
            c.data = d >> POFF; c.tid = tid; c.tdest = tdest; c.user = ip;
            ctrl_q.push_back(c);
        end else if (diff == 0 || diff >= 32'h8000_0000) begin
            m_dup++;
        end else begin
            m_gap++;
            k.data = DW'({last, LOCAL_CID, 8'd3});
            k.user = {KIP_PORT, ip};
            kip_q.push_back(k);
        end
    endfunction

    task automatic send(input logic [7:0] typ, input logic [CW-1:0] ctid, input logic [SW-1:0] seq,
                        input logic tl, input logic [DW-1:0] body, input logic [PW-1:0] tid,
                        input logic [PW-1:0] tdest, input logic [IPW-1:0] ip);
        logic [DW-1:0] d;
        int n;
        d = body;
        d[7:0] = typ;
        d[8 +: CW] = ctid;
        d[8 + CW +: SW] = seq;
        @(posedge clk); #1;
        from_nb_tvalid = 1'b1; from_nb_tdata = d; from_nb_tlast = tl;
        from_nb_tid = tid; from_nb_tdest = tdest; from_nb_tuser = ip;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (from_nb_tready) break;
        end
        if (n == 200) begin
            checks++; errors++;
            $display("FAIL rx_handshake_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        from_nb_tvalid = 1'b0;
        if (n < 200) model(typ, ctid, seq, tl, d, tid, tdest, ip);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (from_nb_tready && ctrl_q.size() == 0 && kip_q.size() == 0) break;
        end
        if (n == 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=ctrl%0d_kip%0d required=empty", ctrl_q.size(), kip_q.size());
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_dup_cnt"}, DW'(dup_cnt), DW'(m_dup));
        chk({tag, "_gap_cnt"}, DW'(gap_cnt), DW'(m_gap));
        chk({tag, "_full_cnt"}, DW'(full_cnt), DW'(m_full));
    endtask

    task automatic clear_model();
        ctrl_q.delete(); kip_q.delete(); model_last.delete();
        m_dup = 0; m_gap = 0; m_full = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl_tvalid", DW'(to_ctrl_tvalid), DW'(0));
        chk("rst_kip_tvalid", DW'(kip_tvalid), DW'(0));
        chk("rst_ctrl_tdata", to_ctrl_tdata, DW'(0));
        chk("rst_rx_ready", DW'(from_nb_tready), DW'(1));
        chk_counts("rst");
    endtask

    function automatic logic [DW-1:0] rand_body();
        logic [DW-1:0] b;
        for (int w = 0; w < DW / 32; w++) b[w*32 +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] body;
        logic [CW-1:0] cid;
        logic [SW-1:0] sq;
        logic [7:0] typ;
        logic tl;
        int r, n;

        do_reset();

        // In-order PUB seq 0, fixed latency and passthrough fields.
        body = '0;
        body[POFF +: 32] = 32'hCDCD_CDCD;
        send(8'd1, 32'hABCD_ABCD, 32'd0, 1'b1, body, 16'h00FA, 16'hACAC, 32'h0A01_0868);
        @(negedge clk); chk("lat_n1_valid", DW'(to_ctrl_tvalid), DW'(0));
        @(negedge clk); chk("lat_n2_valid", DW'(to_ctrl_tvalid), DW'(0));
        @(negedge clk); chk("lat_n3_valid", DW'(to_ctrl_tvalid), DW'(1));
        chk("first_payload", DW'(to_ctrl_tdata[31:0]), DW'(32'hCDCD_CDCD));
        chk("first_tid", DW'(to_ctrl_tid), DW'(16'h00FA));
        chk("first_tdest", DW'(to_ctrl_tdest), DW'(16'hACAC));
        chk("first_tuser", DW'(to_ctrl_tuser), DW'(32'h0A01_0868));
        wait_idle();

        // Duplicates: same seq and a backward jump.
        send(8'd1, 32'hABCD_ABCD, 32'd0, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        send(8'd1, 32'hABCD_ABCD, 32'hFFFF_FFF0, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        wait_idle();
        chk("dup_two", DW'(dup_cnt), DW'(2));
        chk_counts("dup");

        // Gap -> NACK carrying the last accepted seq.
        send(8'd1, 32'hABCD_ABCD, 32'd3, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        wait_idle();
        chk_counts("gap");

        // SEQ_NUM_CHECK from unknown sender must not allocate.
        send(8'd2, 32'h1234_5678, 32'd7, 1'b1, rand_body(), 16'h0001, 16'h0002, 32'h0A00_0001);
        send(8'd1, 32'h1234_5678, 32'd0, 1'b1, rand_body(), 16'h0001, 16'h0002, 32'h0A00_0001);
        send(8'd1, 32'hABCD_ABCD, 32'd1, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        // Ignored beats: non-final and unknown type.
        send(8'd1, 32'hABCD_ABCD, 32'd2, 1'b0, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        send(8'd9, 32'hABCD_ABCD, 32'd2, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        send(8'd1, 32'hABCD_ABCD, 32'd2, 1'b1, rand_body(), 16'h00FA, 16'hACAC, 32'h0A01_0868);
        wait_idle();
        chk_counts("check");

        // Table full: NS+1 distinct senders.
        do_reset();
        for (int i = 0; i <= NS; i++)
            send(8'd1, 32'h5000_0000 + i, 32'd0, 1'b1, rand_body(), 16'(i), 16'(i + 1), 32'h0B00_0000 + i);
        wait_idle();
        chk("full_one", DW'(full_cnt), DW'(1));
        chk_counts("full");

        // Back-pressure hold, then reset while holding.
        ctrl_mode = 2;
        send(8'd1, 32'h5000_0000, 32'd1, 1'b1, rand_body(), 16'h0033, 16'h0044, 32'h0C00_0001);
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (to_ctrl_tvalid) break;
        end
        chk("hold_valid_seen", DW'(to_ctrl_tvalid), DW'(1));
        for (int i = 0; i < 20; i++) begin
            chk("hold_tdata", to_ctrl_tdata, (ctrl_q.size() > 0) ? ctrl_q[0].data : '0);
            chk("hold_valid", DW'(to_ctrl_tvalid), DW'(1));
            chk("hold_rx_ready", DW'(from_nb_tready), DW'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_valid", DW'(to_ctrl_tvalid), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ctrl_mode = 1;
        send(8'd1, 32'h5000_0000, 32'd0, 1'b1, rand_body(), 16'h0033, 16'h0044, 32'h0C00_0001);
        wait_idle();
        chk_counts("post_rst");

        // Randomised traffic with random back-pressure.
        do_reset();
        ctrl_mode = 0;
        kip_mode = 0;
        for (int p = 0; p < 400; p++) begin
            cid = 32'hC000_0000 + 32'($urandom_range(0, 11)) * 32'h1111;
            r = $urandom_range(0, 9);
            typ = (r <= 5 || r == 9) ? 8'd1 : (r <= 7) ? 8'd2 : 8'($urandom_range(4, 255));
            tl = (r != 9);
            if (model_last.exists(cid)) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: sq = model_last[cid] + 1;
                    3:       sq = model_last[cid];
                    4:       sq = model_last[cid] + 32'($urandom_range(2, 5));
                    default: sq = $urandom();
                endcase
            end else begin
                sq = ($urandom_range(0, 3) != 0) ? 32'd0 : $urandom();
            end
            send(typ, cid, sq, tl, rand_body(), 16'($urandom()), 16'($urandom()), $urandom());
        end
        wait_idle();
        chk_counts("rand");
        chk("end_ctrl_q_empty", DW'(ctrl_q.size()), DW'(0));
        chk("end_kip_q_empty", DW'(kip_q.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
